// File: rtl/platform_button_poller_if.sv
// Avalon-MM read channel between the button poller (master) and the button PIO slave.
// Address is constant 0 and readdata returns a fixed number of clocks after the read strobe.
interface platform_button_poller_if;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata
    );
endinterface

// File: rtl/platform_button_poller.sv
// Polls the button PIO every POLL_PERIOD clocks, debounces bit 0, and emits a level, press pulse and press counter.
// Latency: sample captured READ_LATENCY clocks after avm_read; level/pulse update on that capture edge.
// Backpressure: none; one read outstanding at a time. Optional irq/irq_ack under PLATFORM_BUTTON_POLLER_IRQ_EN.
module platform_button_poller #(
    parameter int POLL_PERIOD    = 50000,
    parameter int READ_LATENCY   = 1,
    parameter int DEBOUNCE_COUNT = 4,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    platform_button_poller_if.master   avm,
    input  logic                       count_clear,
    output logic                       button_level,
    output logic                       press_pulse,
    output logic [COUNT_WIDTH-1:0]     press_count
`ifdef PLATFORM_BUTTON_POLLER_IRQ_EN
    ,
    output logic                       irq,
    input  logic                       irq_ack
`endif
);

    localparam int              TW         = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(POLL_PERIOD - 1);
    localparam logic [1:0]      WAIT_LAST  = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;
    localparam logic [3:0]      DB_MAX     = 4'(DEBOUNCE_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        CAPTURE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [1:0]      wait_cnt;
    logic [1:0]      wait_cnt_nxt;
    logic            last_sample;
    logic [3:0]      stable_cnt;
    logic [3:0]      stable_cnt_nxt;
    logic            sample;
    logic            level_change;
    logic            unused_readdata;

    assign avm.avm_address = 2'd0;
    assign avm.avm_read    = (state == READ);
    assign sample          = avm.avm_readdata[0];
    assign unused_readdata = ^avm.avm_readdata[31:1];

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (enable && (timer == TIMER_LAST)) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                wait_cnt_nxt = 2'd0;
                state_nxt    = (READ_LATENCY == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = CAPTURE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 2'd1;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Debounce decision for the sample arriving this cycle; only committed in CAPTURE.
    always_comb begin
        stable_cnt_nxt = 4'd1;
        if (sample == last_sample) begin
            stable_cnt_nxt = (stable_cnt >= DB_MAX) ? DB_MAX : stable_cnt + 4'd1;
        end
        level_change = (stable_cnt_nxt >= DB_MAX) && (sample != button_level);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 2'd0;
            timer        <= '0;
            last_sample  <= 1'b0;
            stable_cnt   <= 4'd0;
            button_level <= 1'b0;
            press_pulse  <= 1'b0;
            press_count  <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            press_pulse <= 1'b0;
            if (enable) begin
                timer <= (timer == TIMER_LAST) ? '0 : timer + TW'(1);
            end
            if (state == CAPTURE) begin
                last_sample <= sample;
                stable_cnt  <= stable_cnt_nxt;
                if (level_change) begin
                    button_level <= sample;
                    press_pulse  <= sample;
                end
            end
            // A clear that lands on a pulse still keeps that press.
            if (count_clear) begin
                press_count <= press_pulse ? COUNT_WIDTH'(1) : '0;
            end else if (press_pulse) begin
                press_count <= press_count + COUNT_WIDTH'(1);
            end
        end
    end

`ifdef PLATFORM_BUTTON_POLLER_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (press_pulse) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_platform_button_poller.sv
// Bench: two pollers (read latency 1 and 3) share stimulus; a transaction-countdown model predicts every output.
module tb_platform_button_poller;
    localparam int P  = 8;
    localparam int DC = 3;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable;
    logic        button;
    logic [30:0] noise;
    logic        cc [2];
    logic        ack [2];

    platform_button_poller_if bus0 ();
    platform_button_poller_if bus1 ();
    assign bus0.avm_readdata = {noise, button};
    assign bus1.avm_readdata = {noise, button};

    logic          lvl0, lvl1, pul0, pul1;
    logic [CW-1:0] cnt0, cnt1;
    logic          o_read [2];
    logic [1:0]    o_addr [2];
    logic          o_level [2];
    logic          o_pulse [2];
    logic [CW-1:0] o_count [2];

    assign o_read[0]  = bus0.avm_read;
    assign o_read[1]  = bus1.avm_read;
    assign o_addr[0]  = bus0.avm_address;
    assign o_addr[1]  = bus1.avm_address;
    assign o_level[0] = lvl0;
    assign o_level[1] = lvl1;
    assign o_pulse[0] = pul0;
    assign o_pulse[1] = pul1;
    assign o_count[0] = cnt0;
    assign o_count[1] = cnt1;

`ifdef PLATFORM_BUTTON_POLLER_IRQ_EN
    logic irq0, irq1;
    logic o_irq [2];
    assign o_irq[0] = irq0;
    assign o_irq[1] = irq1;
`endif

    platform_button_poller #(.POLL_PERIOD(P), .READ_LATENCY(1), .DEBOUNCE_COUNT(DC), .COUNT_WIDTH(CW)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .avm          (bus0),
        .count_clear  (cc[0]),
        .button_level (lvl0),
        .press_pulse  (pul0),
        .press_count  (cnt0)
`ifdef PLATFORM_BUTTON_POLLER_IRQ_EN
        ,
        .irq          (irq0),
        .irq_ack      (ack[0])
`endif
    );

    platform_button_poller #(.POLL_PERIOD(P), .READ_LATENCY(3), .DEBOUNCE_COUNT(DC), .COUNT_WIDTH(CW)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .avm          (bus1),
        .count_clear  (cc[1]),
        .button_level (lvl1),
        .press_pulse  (pul1),
        .press_count  (cnt1)
`ifdef PLATFORM_BUTTON_POLLER_IRQ_EN
        ,
        .irq          (irq1),
        .irq_ack      (ack[1])
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Model: a transaction is a countdown of latency+1 cycles; its first cycle is the read, its last the capture.
    int m_tmr [2];
    int m_left [2];
    int m_cnt [2];
    int m_count [2];
    bit m_last [2];
    bit m_level [2];
    bit m_pulse [2];
    bit m_irq [2];
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        bit np;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_tmr[k] = 0; m_left[k] = 0; m_cnt[k] = 0; m_count[k] = 0;
                m_last[k] = 0; m_level[k] = 0; m_pulse[k] = 0; m_irq[k] = 0;
            end else begin
                if (m_pulse[k]) m_irq[k] = 1;
                else if (ack[k]) m_irq[k] = 0;
                if (cc[k]) m_count[k] = m_pulse[k] ? 1 : 0;
                else if (m_pulse[k]) m_count[k] = (m_count[k] + 1) % (1 << CW);
                np = 0;
                if (m_left[k] == 1) begin
                    if (button == m_last[k]) m_cnt[k] = (m_cnt[k] + 1 > DC) ? DC : m_cnt[k] + 1;
                    else m_cnt[k] = 1;
                    m_last[k] = button;
                    if (m_cnt[k] >= DC && button != m_level[k]) begin
                        m_level[k] = button;
                        np = button;
                    end
                end
                m_pulse[k] = np;
                if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
                else if (enable && m_tmr[k] == P - 1) m_left[k] = lat_of(k) + 1;
                if (enable) m_tmr[k] = (m_tmr[k] + 1) % P;
            end
        end
        if (reset) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("avm_read[%0d]", k), 32'(o_read[k]), 32'(m_left[k] == lat_of(k) + 1));
                chk($sformatf("avm_address[%0d]", k), 32'(o_addr[k]), 0);
                chk($sformatf("button_level[%0d]", k), 32'(o_level[k]), 32'(m_level[k]));
                chk($sformatf("press_pulse[%0d]", k), 32'(o_pulse[k]), 32'(m_pulse[k]));
                chk($sformatf("press_count[%0d]", k), 32'(o_count[k]), 32'(m_count[k]));
`ifdef PLATFORM_BUTTON_POLLER_IRQ_EN
                chk($sformatf("irq[%0d]", k), 32'(o_irq[k]), 32'(m_irq[k]));
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_read(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_read[0] && n < 40);
        if (!o_read[0]) begin
            checks++;
            errors++;
            $display("FAIL poll_timeout: no avm_read within %0d cycles at t=%0t", n, $time);
        end
    endtask

    task automatic poll(input bit b);
        int n;
        button = b;
        noise  = 31'($urandom);
        wait_read(n);
        cyc(5);
    endtask

    task automatic press_release();
        repeat (3) poll(1'b1);
        repeat (3) poll(1'b0);
    endtask

    task automatic check_both(input string name, input int lvl, input int cnt);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_level[%0d]", name, k), 32'(o_level[k]), 32'(lvl));
            chk($sformatf("%s_count[%0d]", name, k), 32'(o_count[k]), 32'(cnt));
        end
    endtask

    initial begin
        int nrd [2];
        int rdc [2][3];
        int n;
        int reads;
        bit seen [2];

        reset = 1'b1; enable = 1'b0; button = 1'b0; noise = '0;
        for (int k = 0; k < 2; k++) begin
            cc[k] = 1'b0; ack[k] = 1'b0; nrd[k] = 0; seen[k] = 1'b0;
            for (int j = 0; j < 3; j++) rdc[k][j] = -1;
        end
        cyc(3);
        check_both("reset", 0, 0);
        chk("reset_read", 32'(o_read[0]), 0);
        reset = 1'b0; enable = 1'b1;

        // Read issue cycles counted from the first clock after reset release.
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (o_read[k]) begin
                    if (nrd[k] < 3) rdc[k][nrd[k]] = c;
                    nrd[k]++;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("read_cycle0[%0d]", k), 32'(rdc[k][0]), 7);
            chk($sformatf("read_cycle1[%0d]", k), 32'(rdc[k][1]), 15);
            chk($sformatf("read_cycle2[%0d]", k), 32'(rdc[k][2]), 23);
        end

        // Bounce 1,0,1,1,0 never reaches three identical samples.
        poll(1); poll(0); poll(1); poll(1); poll(0);
        check_both("bounce", 0, 0);

        // Clean press: level rises on the third identical capture.
        repeat (3) poll(1'b1);
        check_both("press", 1, 1);
`ifdef PLATFORM_BUTTON_POLLER_IRQ_EN
        chk("irq_set0", 32'(o_irq[0]), 1);
        chk("irq_set1", 32'(o_irq[1]), 1);
        ack[0] = 1'b1; ack[1] = 1'b1;
        cyc(1);
        ack[0] = 1'b0; ack[1] = 1'b0;
        cyc(1);
        chk("irq_ack0", 32'(o_irq[0]), 0);
        chk("irq_ack1", 32'(o_irq[1]), 0);
`endif
        repeat (3) poll(1'b0);
        check_both("release", 0, 1);

        // Fifteen more presses wrap the 4-bit counter to zero, then one more gives 1.
        repeat (15) press_release();
        check_both("wrap", 0, 0);
        press_release();
        check_both("after_wrap", 0, 1);

        // Clear (and irq_ack) coincident with the press pulse.
        poll(1'b1); poll(1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                cc[k]  = o_pulse[k];
                ack[k] = o_pulse[k];
                if (o_pulse[k]) seen[k] = 1'b1;
            end
        end
        chk("clr_pulse_seen0", 32'(seen[0]), 1);
        chk("clr_pulse_seen1", 32'(seen[1]), 1);
        check_both("clear_with_press", 1, 1);
`ifdef PLATFORM_BUTTON_POLLER_IRQ_EN
        chk("irq_set_wins0", 32'(o_irq[0]), 1);
        chk("irq_set_wins1", 32'(o_irq[1]), 1);
`endif
        cc[0] = 1'b1; cc[1] = 1'b1; ack[0] = 1'b1; ack[1] = 1'b1;
        cyc(1);
        cc[0] = 1'b0; cc[1] = 1'b0; ack[0] = 1'b0; ack[1] = 1'b0;
        cyc(1);
        check_both("clear_alone", 1, 0);

        // Drop enable in the READ cycle of the press-completing poll.
        repeat (3) poll(1'b0);
        poll(1'b1); poll(1'b1);
        button = 1'b1;
        wait_read(n);
        enable = 1'b0;
        reads = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_read[0] || o_read[1]) reads++;
        end
        chk("disabled_reads", 32'(reads), 0);
        check_both("disabled_capture", 1, 1);
        enable = 1'b1;
        wait_read(n);
        chk("reenable_gap", 32'(n), 8);

        // Reset while the latency-3 poller sits in WAIT.
        cyc(1);
        button = 1'b0;
        reset  = 1'b1;
        cyc(1);
        check_both("mid_reset", 0, 0);
        chk("mid_reset_read0", 32'(o_read[0]), 0);
        chk("mid_reset_read1", 32'(o_read[1]), 0);
`ifdef PLATFORM_BUTTON_POLLER_IRQ_EN
        chk("mid_reset_irq1", 32'(o_irq[1]), 0);
`endif
        reset = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            enable = ($urandom % 8) != 0;
            if ($urandom % 24 == 0) button = ~button;
            noise = 31'($urandom);
            for (int k = 0; k < 2; k++) begin
                cc[k]  = ($urandom % 40) == 0;
                ack[k] = ($urandom % 6) == 0;
            end
            reset = ($urandom % 700) == 0;
        end
        reset = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
